// File: rtl/ddr2sram_b4_ctrl_if.sv
// Request/response port of the DDR-II burst-of-4 SRAM controller.
// The master issues bursts; the slave (controller) accepts them and returns read data.
interface ddr2sram_b4_ctrl_if #(
    parameter int unsigned ADDR_BITS = 18,
    parameter int unsigned DATA_BITS = 36,
    parameter int unsigned BWN       = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [4*DATA_BITS-1:0] req_wdata;
    logic [4*BWN-1:0]       req_bw_b;
    logic                   rsp_valid;
    logic [4*DATA_BITS-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_bw_b,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_bw_b,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ddr2sram_b4_ctrl.sv
// Controller for a DDR-II burst-of-4 common-I/O SRAM: DLL init sequencing, command
// spacing, read-to-write turnaround, write beat issue and read beat reassembly.
module ddr2sram_b4_ctrl #(
    parameter int unsigned ADDR_BITS   = 18,
    parameter int unsigned DATA_BITS   = 36,
    parameter int unsigned BWN         = 4,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic                 K,
    input  logic                 RST_b,
    ddr2sram_b4_ctrl_if.slave    bus,
    output logic [ADDR_BITS-1:0] SA,
    output logic                 LD_b,
    output logic                 RW_b,
    output logic                 DOFF_b,
    output logic [DATA_BITS-1:0] dq_rise,
    output logic [DATA_BITS-1:0] dq_fall,
    output logic [BWN-1:0]       bw_rise_b,
    output logic [BWN-1:0]       bw_fall_b,
    output logic                 dq_oe,
    input  logic [DATA_BITS-1:0] cap_rise,
    input  logic [DATA_BITS-1:0] cap_fall
);
    localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned TurnW = $clog2(RD_LAT + 2);

    typedef enum logic [1:0] {StReset, StLock, StRun} state_e;

    state_e                 r_state;
    logic [LockW-1:0]       r_lock_cnt;
    logic                   r_busy;
    logic [TurnW-1:0]       r_turn;
    logic [4*DATA_BITS-1:0] r_wdata;
    logic [4*BWN-1:0]       r_bw;
    logic                   r_wr_cmd;
    logic                   r_wr_lo;
    logic [RD_LAT+1:0]      r_rd_pipe;
    logic [2*DATA_BITS-1:0] r_rd_lo;

    logic w_ready;
    logic w_accept;

    assign w_ready       = (r_state == StRun) && !r_busy && (!bus.req_write || (r_turn == '0));
    assign w_accept      = bus.req_valid && w_ready;
    assign bus.req_ready = w_ready;

    always_ff @(posedge K or negedge RST_b) begin
        if (!RST_b) begin
            r_state       <= StReset;
            r_lock_cnt    <= '0;
            r_busy        <= 1'b0;
            r_turn        <= '0;
            r_wdata       <= '0;
            r_bw          <= '1;
            r_wr_cmd      <= 1'b0;
            r_wr_lo       <= 1'b0;
            r_rd_pipe     <= '0;
            r_rd_lo       <= '0;
            SA            <= '0;
            LD_b          <= 1'b1;
            RW_b          <= 1'b1;
            DOFF_b        <= 1'b0;
            dq_rise       <= '0;
            dq_fall       <= '0;
            bw_rise_b     <= '1;
            bw_fall_b     <= '1;
            dq_oe         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            case (r_state)
                StReset: begin
                    r_state    <= StLock;
                    r_lock_cnt <= '0;
                    DOFF_b     <= 1'b1;
                end
                StLock: begin
                    if (r_lock_cnt == LockW'(LOCK_CYCLES - 1)) begin
                        r_state <= StRun;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                StRun:   r_state <= StRun;
                default: r_state <= StReset;
            endcase

            r_busy <= w_accept;

            // Bus turnaround: a write may not follow a read until its capture window is clear.
            if (w_accept && !bus.req_write) begin
                r_turn <= TurnW'(RD_LAT + 1);
            end else if (r_turn != '0) begin
                r_turn <= r_turn - 1'b1;
            end

            LD_b <= !w_accept;
            RW_b <= !(w_accept && bus.req_write);
            if (w_accept) begin
                SA <= bus.req_addr;
            end
            if (w_accept && bus.req_write) begin
                r_wdata <= bus.req_wdata;
                r_bw    <= bus.req_bw_b;
            end

            r_wr_cmd <= w_accept && bus.req_write;
            r_wr_lo  <= r_wr_cmd;
            if (r_wr_cmd) begin
                dq_rise   <= r_wdata[DATA_BITS-1:0];
                dq_fall   <= r_wdata[2*DATA_BITS-1:DATA_BITS];
                bw_rise_b <= r_bw[BWN-1:0];
                bw_fall_b <= r_bw[2*BWN-1:BWN];
                dq_oe     <= 1'b1;
            end else if (r_wr_lo) begin
                dq_rise   <= r_wdata[3*DATA_BITS-1:2*DATA_BITS];
                dq_fall   <= r_wdata[4*DATA_BITS-1:3*DATA_BITS];
                bw_rise_b <= r_bw[3*BWN-1:2*BWN];
                bw_fall_b <= r_bw[4*BWN-1:3*BWN];
                dq_oe     <= 1'b1;
            end else begin
                dq_rise   <= '0;
                dq_fall   <= '0;
                bw_rise_b <= '1;
                bw_fall_b <= '1;
                dq_oe     <= 1'b0;
            end

            // Bit k of the tag pipe marks a read whose command cycle was k cycles ago.
            r_rd_pipe <= {r_rd_pipe[RD_LAT:0], w_accept && !bus.req_write};
            if (r_rd_pipe[RD_LAT]) begin
                r_rd_lo <= {cap_fall, cap_rise};
            end
            bus.rsp_valid <= r_rd_pipe[RD_LAT+1];
            if (r_rd_pipe[RD_LAT+1]) begin
                bus.rsp_rdata <= {cap_fall, cap_rise, r_rd_lo};
            end
        end
    end
endmodule

// File: tb/tb_ddr2sram_b4_ctrl.sv
// Bench for ddr2sram_b4_ctrl: directed and random traffic against a transaction-level
// model (accept-cycle offsets plus a reference memory) and an attached SRAM model.
module tb_ddr2sram_b4_ctrl;
    localparam int AB   = 18;
    localparam int DB   = 36;
    localparam int BW   = 4;
    localparam int RL   = 2;
    localparam int LOCK = 1024;

    logic          K = 1'b0;
    logic          RST_b = 1'b0;
    logic [AB-1:0] SA;
    logic          LD_b, RW_b, DOFF_b, dq_oe;
    logic [DB-1:0] dq_rise, dq_fall, cap_rise, cap_fall;
    logic [BW-1:0] bw_rise_b, bw_fall_b;

    ddr2sram_b4_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .BWN(BW)) bus ();

    ddr2sram_b4_ctrl #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .BWN(BW), .RD_LAT(RL), .LOCK_CYCLES(LOCK)
    ) dut (
        .K(K), .RST_b(RST_b), .bus(bus), .SA(SA), .LD_b(LD_b), .RW_b(RW_b),
        .DOFF_b(DOFF_b), .dq_rise(dq_rise), .dq_fall(dq_fall), .bw_rise_b(bw_rise_b),
        .bw_fall_b(bw_fall_b), .dq_oe(dq_oe), .cap_rise(cap_rise), .cap_fall(cap_fall)
    );

    always #5 K = ~K;

    int cyc = 0;
    always @(posedge K) cyc <= cyc + 1;

    typedef struct {
        logic          v;
        logic          w;
        logic [AB-1:0] a;
        logic [143:0]  d;
        logic [15:0]   bw;
        logic [143:0]  e;
    } acc_t;

    typedef struct {
        int           cyc;
        int           kind;   // 0 req_ready, 1 DOFF_b, 2 response
        logic [143:0] val;
    } pin_t;

    acc_t         ring [16];
    pin_t         pins [$];
    int           pin_rd = 0;
    logic [143:0] ref_mem [int];
    logic [143:0] sram_mem [int];

    int           n_total = 0;
    int           n_bad = 0;
    logic         m_rel = 1'b0;
    int           m_r0 = 0;
    int           m_last_acc = -100;
    int           m_last_rd = -100;
    logic [AB-1:0] m_sa = '0;

    logic         s_w [16];
    logic         s_r [16];
    logic [AB-1:0] s_wa [16];
    logic [143:0] s_rd [16];
    logic [71:0]  s_lo;
    logic [7:0]   s_lobw;

    function automatic logic [143:0] apply_bw(input logic [143:0] old, input logic [143:0] d,
                                              input logic [15:0] bw);
        logic [143:0] r;
        r = old;
        for (int l = 0; l < 16; l++) begin
            if (!bw[l]) r[l*9 +: 9] = d[l*9 +: 9];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ring[i].v = 1'b0;
            s_w[i] = 1'b0;
            s_r[i] = 1'b0;
        end
        cap_rise = '0;
        cap_fall = '0;
    end

    // Compare process: model expectations, pinned literals and the SRAM model.
    always @(negedge K) begin
        int t, wk;
        logic run, e_doff, e_ready, e_oe, acc, win;
        logic [DB-1:0] e_dr, e_df;
        logic [BW-1:0] e_br, e_bf;
        acc_t p1, p2, p3, pr;
        logic [143:0] old;
        t = cyc;
        if (!RST_b) begin
            m_rel = 1'b0;
            m_sa = '0;
            m_last_acc = -100;
            m_last_rd = -100;
            for (int i = 0; i < 16; i++) begin
                ring[i].v = 1'b0;
                s_w[i] = 1'b0;
                s_r[i] = 1'b0;
            end
        end else if (!m_rel) begin
            m_rel = 1'b1;
            m_r0 = t + 1;
        end

        run     = m_rel && (t >= m_r0 + LOCK);
        e_doff  = m_rel && (t >= m_r0);
        e_ready = run && (t - m_last_acc >= 2) &&
                  (!bus.req_write || (t - m_last_rd >= RL + 2));
        p1 = ring[(t - 1) & 15];
        p2 = ring[(t - 2) & 15];
        p3 = ring[(t - 3) & 15];
        pr = ring[(t - RL - 3) & 15];

        chk("req_ready", bus.req_ready, e_ready);
        chk("doff_b", DOFF_b, e_doff);
        if (p1.v) m_sa = p1.a;
        chk("ld_b", LD_b, !p1.v);
        chk("rw_b", RW_b, !(p1.v && p1.w));
        chk("sa", SA, m_sa);

        e_oe = 1'b1;
        if (p2.v && p2.w) begin
            e_dr = p2.d[35:0];    e_df = p2.d[71:36];   e_br = p2.bw[3:0];  e_bf = p2.bw[7:4];
        end else if (p3.v && p3.w) begin
            e_dr = p3.d[107:72];  e_df = p3.d[143:108]; e_br = p3.bw[11:8]; e_bf = p3.bw[15:12];
        end else begin
            e_oe = 1'b0;
            e_dr = '0;            e_df = '0;            e_br = '1;          e_bf = '1;
        end
        chk("dq_oe", dq_oe, e_oe);
        chk("bw_rise_b", bw_rise_b, e_br);
        chk("bw_fall_b", bw_fall_b, e_bf);
        if (e_oe || !run) begin
            chk("dq_rise", dq_rise, e_dr);
            chk("dq_fall", dq_fall, e_df);
        end
        chk("rsp_valid", bus.rsp_valid, pr.v && !pr.w);
        if (pr.v && !pr.w) chk("rsp_rdata", bus.rsp_rdata, pr.e);
        if (!run) chk("rsp_rdata_idle", bus.rsp_rdata, '0);

        while (pin_rd < pins.size() && pins[pin_rd].cyc <= t) begin
            if (pins[pin_rd].cyc < t) begin
                chk("pin_stale", 144'(pins[pin_rd].cyc), 144'(t));
            end else if (pins[pin_rd].kind == 0) begin
                chk("pin_ready", bus.req_ready, pins[pin_rd].val);
            end else if (pins[pin_rd].kind == 1) begin
                chk("pin_doff", DOFF_b, pins[pin_rd].val);
            end else begin
                chk("pin_rsp_valid", bus.rsp_valid, 1);
                chk("pin_rsp_data", bus.rsp_rdata, pins[pin_rd].val);
            end
            pin_rd++;
        end

        // Model update: writes land in the reference memory at accept, reads snapshot it.
        acc = bus.req_valid && e_ready;
        ring[t & 15].v  = acc;
        ring[t & 15].w  = bus.req_write;
        ring[t & 15].a  = bus.req_addr;
        ring[t & 15].d  = bus.req_wdata;
        ring[t & 15].bw = bus.req_bw_b;
        ring[t & 15].e  = '0;
        if (acc) begin
            m_last_acc = t;
            old = ref_mem.exists(int'(bus.req_addr)) ? ref_mem[int'(bus.req_addr)] : '0;
            if (bus.req_write) begin
                ref_mem[int'(bus.req_addr)] = apply_bw(old, bus.req_wdata, bus.req_bw_b);
            end else begin
                m_last_rd = t;
                ring[t & 15].e = old;
            end
        end

        // SRAM model on the physical pins.
        win = 1'b0;
        for (int k = RL - 1; k <= RL + 2; k++) begin
            if (s_r[(t - k) & 15]) win = 1'b1;
        end
        if (win) chk("dq_conflict", dq_oe, 0);
        s_w[t & 15]  = (LD_b == 1'b0) && (RW_b == 1'b0);
        s_wa[t & 15] = SA;
        if (s_w[(t - 1) & 15]) begin
            s_lo   = {dq_fall, dq_rise};
            s_lobw = {bw_fall_b, bw_rise_b};
        end
        if (s_w[(t - 2) & 15]) begin
            wk  = int'(s_wa[(t - 2) & 15]);
            old = sram_mem.exists(wk) ? sram_mem[wk] : '0;
            sram_mem[wk] = apply_bw(old, {dq_fall, dq_rise, s_lo},
                                    {bw_fall_b, bw_rise_b, s_lobw});
        end
        s_r[t & 15]  = (LD_b == 1'b0) && (RW_b == 1'b1);
        s_rd[t & 15] = sram_mem.exists(int'(SA)) ? sram_mem[int'(SA)] : '0;
        if (s_r[(t - RL) & 15]) begin
            cap_rise = s_rd[(t - RL) & 15][35:0];
            cap_fall = s_rd[(t - RL) & 15][71:36];
        end else if (s_r[(t - RL - 1) & 15]) begin
            cap_rise = s_rd[(t - RL - 1) & 15][107:72];
            cap_fall = s_rd[(t - RL - 1) & 15][143:108];
        end else begin
            cap_rise = DB'({$urandom, $urandom});
            cap_fall = DB'({$urandom, $urandom});
        end
    end

    task automatic step();
        @(posedge K);
        #1;
    endtask

    task automatic issue(input logic w, input logic [AB-1:0] a, input logic [143:0] d,
                         input logic [15:0] bw, output int acc_cyc);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_bw_b  = bw;
        for (int i = 0; i < 64; i++) begin
            step();
            if (m_last_acc == cyc - 1) begin
                acc_cyc = cyc - 1;
                bus.req_valid = 1'b0;
                bus.req_write = 1'b0;
                return;
            end
        end
        $display("FAIL issue_timeout cyc=%0d got=no_accept want=accept", cyc);
        $fatal(1, "request never accepted");
    endtask

    task automatic release_and_lock();
        int rel;
        RST_b = 1'b1;
        rel = cyc;
        pins.push_back('{cyc: rel + 1, kind: 1, val: 144'(1)});
        pins.push_back('{cyc: rel + LOCK, kind: 0, val: 144'(0)});
        pins.push_back('{cyc: rel + LOCK + 1, kind: 0, val: 144'(1)});
        while (cyc <= rel + LOCK + 2) step();
    endtask

    localparam logic [143:0] Data1 = {36'h444444444, 36'h333333333, 36'h222222222, 36'h111111111};
    localparam logic [143:0] ByteRes = {36'h007FFFFFF, 36'hFF803FFFF, 36'hFFFFC01FF, 36'hFFFFFFE00};

    initial begin
        int a, a2;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_bw_b  = '1;
        repeat (3) step();
        release_and_lock();

        issue(1'b1, 18'h11111, Data1, 16'h0000, a);
        repeat (4) step();
        issue(1'b0, 18'h11111, '0, '1, a);
        pins.push_back('{cyc: a + 5, kind: 2, val: Data1});
        repeat (6) step();

        // Read then a pending write: the write must wait for the turnaround.
        issue(1'b0, 18'h11111, '0, '1, a);
        pins.push_back('{cyc: a + 3, kind: 0, val: 144'(0)});
        pins.push_back('{cyc: a + 4, kind: 0, val: 144'(1)});
        issue(1'b1, 18'h22222, 144'({$urandom, $urandom, $urandom, $urandom, $urandom}),
              16'h0000, a2);
        repeat (6) step();

        issue(1'b0, 18'h11111, '0, '1, a);
        pins.push_back('{cyc: a + 5, kind: 2, val: Data1});
        issue(1'b0, 18'h11111, '0, '1, a2);
        pins.push_back('{cyc: a + 7, kind: 2, val: Data1});
        repeat (8) step();

        issue(1'b1, 18'h33333, '1, 16'h0000, a);
        issue(1'b1, 18'h33333, '0, 16'h7BDE, a);
        issue(1'b0, 18'h33333, '0, '1, a);
        pins.push_back('{cyc: a + 5, kind: 2, val: ByteRes});
        repeat (5) step();

        // Reset one cycle after a read accept: no response, immediate DOFF_b drop, relock.
        issue(1'b0, 18'h11111, '0, '1, a);
        RST_b = 1'b0;
        pins.push_back('{cyc: cyc, kind: 1, val: 144'(0)});
        repeat (3) step();
        release_and_lock();

        for (int i = 0; i < 1500; i++) begin
            bus.req_valid = ($urandom_range(0, 2) != 0);
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = AB'($urandom_range(0, 15));
            bus.req_wdata = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
            bus.req_bw_b  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            step();
        end
        bus.req_valid = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
